// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receiver.
// The even-parity variant is selected with the UART_PARITY_EN macro.
package uart_pkg;
  localparam int DATA_WIDTH  = 8;
  localparam int OSR_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;
endpackage

// File: rtl/uart_rx_os16_if.sv
// Receiver-side bundle: serial line in, received byte and status out, FSM state for debug.
// done_rx is a valid-only pulse with no ready: dout/frame_err/parity_err are
// valid in exactly that cycle and the consumer must take them then.
interface uart_rx_if;
  import uart_pkg::*;

  logic                  rx;
  logic [DATA_WIDTH-1:0] dout;
  logic                  done_rx;
  logic                  frame_err;
  logic                  parity_err;
  logic                  busy;
  rx_state_t             state;

  modport master (output rx, input dout, done_rx, frame_err, parity_err, busy, state);
  modport slave  (input rx, output dout, done_rx, frame_err, parity_err, busy, state);
endinterface

// File: rtl/uart_os_tick_gen.sv
// Prescaler: one os_tick every DIV clocks; restart realigns it to a start edge.
module uart_os_tick_gen #(
  parameter int DIV = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic os_tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign os_tick = (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (restart || os_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/uart_rx_os16.sv
// Oversampling UART receiver with 3-sample mid-bit majority vote.
// Define UART_PARITY_EN to expect an even-parity bit between data and stop.
module uart_rx_os16
  import uart_pkg::*;
#(
  parameter int clk_freq = 1000000,
  parameter int baudrate = 9600,
  parameter int OSR      = OSR_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  uart_rx_if.slave bus
);
  localparam int DIV = clk_freq / (baudrate * OSR);
  localparam int TW  = $clog2(OSR);
  localparam logic [TW-1:0] DEC_TICK  = TW'(OSR / 2 + 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(OSR - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_WIDTH - 1);

  logic                  sync1, sync2, rx_prev;
  logic [1:0]            smp;
  logic                  os_tick, restart, vote, decide, fall;
  logic [TW-1:0]         tick_cnt;
  logic [2:0]            bit_cnt;
  logic [DATA_WIDTH-1:0] shreg, dout_q;
  logic                  done_q, ferr_q;
  rx_state_t             state, state_next;
`ifdef UART_PARITY_EN
  logic                  par_bit, perr_q;
`endif

  uart_os_tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .os_tick (os_tick)
  );

  // rx_prev extends the synchronizer so the edge detector never looks at the first flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      rx_prev <= 1'b1;
      smp     <= 2'b11;
    end else begin
      sync1   <= bus.rx;
      sync2   <= sync1;
      rx_prev <= sync2;
      if (os_tick) smp <= {smp[0], sync2};
    end
  end

  // smp holds ticks OSR/2-1 and OSR/2; sync2 is tick OSR/2+1 itself.
  assign fall   = rx_prev & ~sync2;
  assign vote   = (smp[1] & smp[0]) | (smp[1] & sync2) | (smp[0] & sync2);
  assign decide = os_tick && (tick_cnt == DEC_TICK) && (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    restart    = 1'b0;
    case (state)
      IDLE: if (fall) begin
        state_next = START;
        restart    = 1'b1;
      end
      START: if (decide) state_next = vote ? IDLE : DATA;
      DATA: if (decide && bit_cnt == LAST_BIT) begin
`ifdef UART_PARITY_EN
        state_next = PARITY;
`else
        state_next = STOP;
`endif
      end
`ifdef UART_PARITY_EN
      PARITY: if (decide) state_next = STOP;
`endif
      // Leaving at mid-stop lets a zero-gap next start edge be caught.
      STOP: if (decide) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      dout_q   <= '0;
      done_q   <= 1'b0;
      ferr_q   <= 1'b0;
`ifdef UART_PARITY_EN
      par_bit  <= 1'b0;
      perr_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      ferr_q <= 1'b0;
`ifdef UART_PARITY_EN
      perr_q <= 1'b0;
`endif
      if (state == IDLE) begin
        tick_cnt <= '0;
        bit_cnt  <= '0;
      end else if (os_tick) begin
        tick_cnt <= (tick_cnt == LAST_TICK) ? '0 : tick_cnt + 1'b1;
      end
      if (decide) begin
        case (state)
          START: bit_cnt <= '0;
          DATA: begin
            shreg   <= {vote, shreg[DATA_WIDTH-1:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
`ifdef UART_PARITY_EN
          PARITY: par_bit <= vote;
`endif
          STOP: begin
            dout_q <= shreg;
            done_q <= 1'b1;
            ferr_q <= ~vote;
`ifdef UART_PARITY_EN
            perr_q <= ^{shreg, par_bit};
`endif
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.dout      = dout_q;
  assign bus.done_rx   = done_q;
  assign bus.frame_err = ferr_q;
`ifdef UART_PARITY_EN
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif
  assign bus.busy  = (state != IDLE);
  assign bus.state = state;
endmodule
